// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped port controller: register offsets,
// STATUS bit positions and the debounce FSM state type.
package mmio_pkg;

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int ST_PENDING = 0;
  localparam int ST_OVERRUN = 1;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability filter: a new 8-bit value is
// accepted only after it has been seen unchanged for DEBOUNCE_CYCLES samples.
module input_debouncer
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] raw_i,
  output logic [7:0] debounced_o,
  output logic       commit_o,
  output deb_state_e state_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       sync1_q, sync2_q;
  logic [7:0]       deb_q, deb_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deb_state_e       state_q, state_d;
  logic             commit;

  always_comb begin
    deb_d   = deb_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != deb_q) begin
          state_d = SETTLING;
          cand_d  = sync2_q;
          cnt_d   = '0;
        end
      end
      default: begin
        // Bouncing back to the accepted value abandons the candidate silently.
        if (sync2_q == deb_q) begin
          state_d = STABLE;
        end else if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          deb_d   = cand_q;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign debounced_o = deb_q;
  assign commit_o    = commit;
  assign state_o     = state_q;

endmodule

// File: rtl/mmio_port_controller.sv
// 16-byte I/O window beside data memory: OUT/IN/STATUS/CTRL registers, address
// decode for load-data steering, and change-event flags fed by the debouncer.
module mmio_port_controller
  import mmio_pkg::*;
#(
  parameter logic [31:0] IO_BASE         = 32'h1001_0020,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic [31:0] ReadData,
  output logic        IOSelect,
  output logic        Event,
  output logic        DbgState
);

  logic [31:0] port_out_q, port_out_d;
  logic        pend_q, pend_d;
  logic        ovr_q, ovr_d;
  logic        en_q, en_d;
  logic [7:0]  debounced;
  logic        commit;
  deb_state_e  deb_state;
  logic [1:0]  offset;
  logic        wr_en, status_clr;
  logic        unused_addr_bits;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk         (clk),
    .reset       (reset),
    .raw_i       (PortIn),
    .debounced_o (debounced),
    .commit_o    (commit),
    .state_o     (deb_state)
  );

  assign offset           = Address[3:2];
  assign unused_addr_bits = ^Address[1:0];
  assign IOSelect         = (Address[31:4] == IO_BASE[31:4]);
  assign wr_en            = IOSelect & MemWrite;
  assign status_clr       = IOSelect & MemRead & (offset == OFF_STATUS);

  always_comb begin
    port_out_d = port_out_q;
    en_d       = en_q;
    pend_d     = pend_q;
    ovr_d      = ovr_q;
    if (wr_en && offset == OFF_OUT)  port_out_d = WriteData;
    if (wr_en && offset == OFF_CTRL) en_d = WriteData[0];
    // A commit landing on the same edge as a STATUS read wins: the event is
    // fresh, so it is pending but not an overrun.
    if (commit && en_q) begin
      pend_d = 1'b1;
      ovr_d  = status_clr ? 1'b0 : (ovr_q | pend_q);
    end else if (status_clr) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_out_q <= '0;
      pend_q     <= 1'b0;
      ovr_q      <= 1'b0;
      en_q       <= 1'b1;
    end else begin
      port_out_q <= port_out_d;
      pend_q     <= pend_d;
      ovr_q      <= ovr_d;
      en_q       <= en_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (IOSelect) begin
      case (offset)
        OFF_OUT:    ReadData = port_out_q;
        OFF_IN:     ReadData = {24'b0, debounced};
        OFF_STATUS: begin
          ReadData[ST_PENDING] = pend_q;
          ReadData[ST_OVERRUN] = ovr_q;
        end
        default:    ReadData = {31'b0, en_q};
      endcase
    end
  end

  assign PortOut  = port_out_q;
  assign Event    = pend_q;
  assign DbgState = deb_state;

endmodule

// File: tb/tb_mmio_port_controller.sv
// Bench for mmio_port_controller: directed scenarios and random traffic,
// compared each cycle against a run-length model of the debounced input.
module tb_mmio_port_controller;

  localparam logic [31:0] BASE = 32'h1001_0020;
  localparam int          D    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [7:0]  port_in = '0;
  logic [31:0] port_out, read_data;
  logic        io_select, event_o, dbg_state;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_out = '0;
  logic [7:0]  m_deb = '0, m_s1 = '0, m_s2 = '0, run_val = '0;
  int          run_len = 0;
  logic        m_pend = 1'b0, m_ovr = 1'b0, m_en = 1'b1;
  logic [7:0]  cur_pin = '0;
  logic [31:0] rd;

  mmio_port_controller #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (address),
    .WriteData (write_data),
    .MemWrite  (mem_write),
    .MemRead   (mem_read),
    .PortIn    (port_in),
    .PortOut   (port_out),
    .ReadData  (read_data),
    .IOSelect  (io_select),
    .Event     (event_o),
    .DbgState  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return m_out;
      2'd1:    return {24'h0, m_deb};
      2'd2:    return {30'h0, m_ovr, m_pend};
      default: return {31'h0, m_en};
    endcase
  endfunction

  // A value is accepted once the synchronized input has shown it, differing
  // from the accepted value, on D+1 consecutive edges.
  task automatic model_edge(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                            input logic we, input logic re, input logic [7:0] pin);
    logic sel, clr, commit;
    if (rst) begin
      m_out = '0; m_deb = '0; m_s1 = '0; m_s2 = '0; run_val = '0; run_len = 0;
      m_pend = 1'b0; m_ovr = 1'b0; m_en = 1'b1;
      return;
    end
    sel    = (a[31:4] == BASE[31:4]);
    clr    = sel && re && (a[3:2] == 2'd2);
    commit = 1'b0;
    if (m_s2 == m_deb) begin
      run_len = 0;
    end else begin
      if (run_len > 0 && m_s2 == run_val) run_len++;
      else begin
        run_val = m_s2;
        run_len = 1;
      end
      if (run_len == D + 1) begin
        commit  = 1'b1;
        m_deb   = m_s2;
        run_len = 0;
      end
    end
    if (commit && m_en) begin
      m_ovr  = clr ? 1'b0 : (m_ovr | m_pend);
      m_pend = 1'b1;
    end else if (clr) begin
      m_pend = 1'b0;
      m_ovr  = 1'b0;
    end
    if (sel && we && a[3:2] == 2'd0) m_out = wd;
    if (sel && we && a[3:2] == 2'd3) m_en = wd[0];
    m_s2 = m_s1;
    m_s1 = pin;
  endtask

  // One full clock cycle; entered and left just after a falling edge.
  task automatic cycle(input logic rst, input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic re, input logic [7:0] pin,
                       output logic [31:0] rd_obs);
    reset = rst; address = a; write_data = wd; mem_write = we; mem_read = re; port_in = pin;
    #1;
    check("iosel", {31'h0, io_select}, {31'h0, a[31:4] == BASE[31:4]});
    check("rdata", read_data, exp_read(a));
    rd_obs = read_data;
    @(posedge clk);
    model_edge(rst, a, wd, we, re, pin);
    @(negedge clk);
    check("portout", port_out, m_out);
    check("event", {31'h0, event_o}, {31'h0, m_pend});
  endtask

  task automatic idle(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, cur_pin, dummy);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    cycle(1'b0, a, d, 1'b1, 1'b0, cur_pin, dummy);
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] r);
    cycle(1'b0, a, 32'h0, 1'b0, 1'b1, cur_pin, r);
  endtask

  task automatic do_reset(input int n);
    logic [31:0] dummy;
    for (int i = 0; i < n; i++) cycle(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, cur_pin, dummy);
  endtask

  initial begin
    @(negedge clk);
    // reset state
    do_reset(2);
    check("rst_portout", port_out, 32'h0);
    check("rst_event", {31'h0, event_o}, 32'h0);
    check("rst_dbg", {31'h0, dbg_state}, 32'h0);
    load(BASE + 32'hC, rd);  check("rst_ctrl", rd, 32'h1);
    load(BASE + 32'h4, rd);  check("rst_in", rd, 32'h0);

    // OUT store, in and out of the window
    store(BASE, 32'hDEAD_BEEF);
    check("out_store", port_out, 32'hDEAD_BEEF);
    store(32'h1001_0030, 32'h1234_5678);
    check("out_outside", port_out, 32'hDEAD_BEEF);
    load(BASE + 32'h3, rd);  check("out_load", rd, 32'hDEAD_BEEF);

    // short glitch is rejected
    cur_pin = 8'hFF; idle(3);
    cur_pin = 8'h00; idle(10);
    load(BASE + 32'h4, rd);  check("glitch_in", rd, 32'h0);
    check("glitch_event", {31'h0, event_o}, 32'h0);

    // latency: cycle j ends with edge k+j
    cur_pin = 8'hA5;
    for (int j = 0; j <= 6; j++) begin
      load(BASE + 32'h4, rd);
      check("lat_in_early", rd, 32'h0);
      if (j == 5) check("lat_event_k5", {31'h0, event_o}, 32'h0);
      if (j == 6) check("lat_event_k6", {31'h0, event_o}, 32'h1);
    end
    load(BASE + 32'h4, rd);  check("lat_in", rd, 32'hA5);
    load(BASE + 32'h8, rd);  check("lat_status", rd, 32'h1);

    // two commits unread -> overrun, then read clears
    cur_pin = 8'h11; idle(8);
    cur_pin = 8'h22; idle(8);
    load(BASE + 32'h8, rd);  check("ovr_status", rd, 32'h3);
    load(BASE + 32'h8, rd);  check("ovr_cleared", rd, 32'h0);

    // STATUS read on the commit edge
    cur_pin = 8'h44; idle(8);
    cur_pin = 8'h55; idle(6);
    load(BASE + 32'h8, rd);  check("sim_old", rd, 32'h1);
    load(BASE + 32'h8, rd);  check("sim_new", rd, 32'h1);
    load(BASE + 32'h4, rd);  check("sim_in", rd, 32'h55);

    // change detect disabled
    store(BASE + 32'hC, 32'hFFFF_FFFE);
    load(BASE + 32'hC, rd);  check("ctrl_off", rd, 32'h0);
    cur_pin = 8'h66; idle(8);
    load(BASE + 32'h8, rd);  check("dis_status", rd, 32'h0);
    load(BASE + 32'h4, rd);  check("dis_in", rd, 32'h66);
    store(BASE + 32'hC, 32'h1);

    // reset two cycles into settling
    cur_pin = 8'h77; idle(4);
    cur_pin = 8'h00; do_reset(2);
    load(BASE + 32'h4, rd);  check("rstmid_in", rd, 32'h0);
    check("rstmid_event", {31'h0, event_o}, 32'h0);
    idle(8);
    load(BASE + 32'h4, rd);  check("rstmid_in_late", rd, 32'h0);
    check("rstmid_event_late", {31'h0, event_o}, 32'h0);

    // random traffic
    begin
      int hold = 0;
      logic [31:0] a, wd;
      logic we, re, rst;
      for (int i = 0; i < 1500; i++) begin
        if (hold == 0) begin
          cur_pin = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
          hold = $urandom_range(1, 9);
        end
        hold--;
        a   = ($urandom_range(0, 9) < 8) ? (BASE + 32'($urandom_range(0, 15))) : $urandom;
        wd  = $urandom;
        we  = ($urandom_range(0, 3) == 0);
        re  = ($urandom_range(0, 1) == 0);
        rst = ($urandom_range(0, 299) == 0);
        cycle(rst, a, wd, we, re, cur_pin, rd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
